// File: rtl/dmem_responder.sv
// dmem_responder
//   Memory-side end of the core's MEM-stage load/store port. Holds an
//   internal word array and answers one byte/half/word load or store at a
//   time, inserting WAIT_CYCLES wait states between accept and response.
//   Load data comes back right-justified with the upper bits zero.
//
// Parameters
//   BASE_ADDR    byte address of word 0
//   DEPTH_WORDS  number of 32-bit words (power of 2, at least 2)
//   WAIT_CYCLES  wait states between accept and response (0..15)
//
// Ports
//   clk, reset   clock; synchronous active-high reset
//   i_req        access request, held stable until o_ready
//   i_write      1 = store, 0 = load
//   i_addr       byte address
//   i_wdata      store data, low byte/half/word used per i_memSize
//   i_memSize    00 byte, 01 half, 10 word, 11 reserved (error)
//   o_rdata      load data, lane shifted to bit 0; holds until next response
//   o_ready      one-cycle completion pulse
//   o_stall      i_req & ~o_ready, to the hazard unit
//   o_err        pulses with o_ready on misaligned/out-of-range/reserved size
//   o_rdCount    completed error-free loads
//   o_wrCount    completed error-free stores
//
// Configuration
//   DMEM_ACCESS_COUNT_EN  when defined, o_rdCount/o_wrCount are live wrapping
//                         counters; otherwise they are tied to zero.

module dmem_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h0002_0000,
  parameter int          DEPTH_WORDS = 4096,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic        i_write,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic [1:0]  i_memSize,
  output logic [31:0] o_rdata,
  output logic        o_ready,
  output logic        o_stall,
  output logic        o_err,
  output logic [31:0] o_rdCount,
  output logic [31:0] o_wrCount
);

  localparam int          IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN      = 33'(DEPTH_WORDS) << 2;
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);
  localparam bit          NO_WAIT   = (WAIT_CYCLES == 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            state;
  logic [3:0]        wait_cnt;
  logic [31:0]       mem [DEPTH_WORDS];

  // Request fields as seen by the edge that forms the response
  logic              write_p0;
  logic              err_p0;
  logic [1:0]        size_p0;
  logic [1:0]        off_p0;
  logic [IDX_W-1:0]  idx_p0;

  // Request fields captured at accept
  logic              write_p1;
  logic              err_p1;
  logic [1:0]        size_p1;
  logic [1:0]        off_p1;
  logic [IDX_W-1:0]  idx_p1;
  logic [31:0]       wdata_p1;

  logic              accept;
  logic              go_resp;

  // Any of: reserved size, misaligned half/word, address outside the window.
  // The window test is done in 33 bits so addresses below BASE_ADDR wrap to
  // a huge value and fail the same upper-bound compare.
  function automatic logic access_err(input logic [31:0] a, input logic [1:0] sz);
    logic [32:0] rel;
    rel = {1'b0, a} - {1'b0, BASE_ADDR};
    access_err = (sz == 2'b11)
               || (sz == 2'b01 && a[0])
               || (sz == 2'b10 && a[1:0] != 2'b00)
               || (rel >= SPAN);
  endfunction

  function automatic logic [IDX_W-1:0] word_index(input logic [31:0] a);
    word_index = IDX_W'((a - BASE_ADDR) >> 2);
  endfunction

  function automatic logic [31:0] load_lane(input logic [31:0] w,
                                            input logic [1:0]  off,
                                            input logic [1:0]  sz);
    case (sz)
      2'b00:   load_lane = {24'd0, w[{off, 3'b000} +: 8]};
      2'b01:   load_lane = {16'd0, w[{off[1], 4'b0000} +: 16]};
      default: load_lane = w;
    endcase
  endfunction

  // Byte-enable merge: only the addressed lane changes.
  function automatic logic [31:0] store_merge(input logic [31:0] old,
                                              input logic [31:0] wd,
                                              input logic [1:0]  off,
                                              input logic [1:0]  sz);
    logic [31:0] r;
    r = old;
    case (sz)
      2'b00:   r[{off, 3'b000} +: 8]     = wd[7:0];
      2'b01:   r[{off[1], 4'b0000} +: 16] = wd[15:0];
      default: r = wd;
    endcase
    store_merge = r;
  endfunction

  assign accept  = (state == S_IDLE) && i_req;
  // With no wait states the response is formed on the accept edge itself,
  // so the request fields must come straight from the inputs.
  assign go_resp = (accept && NO_WAIT)
                || ((state == S_WAIT) && i_req && (wait_cnt == 4'd1));
  assign o_stall = i_req & ~o_ready;

  always_comb begin
    write_p0 = write_p1;
    err_p0   = err_p1;
    size_p0  = size_p1;
    off_p0   = off_p1;
    idx_p0   = idx_p1;
    if (state == S_IDLE) begin
      write_p0 = i_write;
      err_p0   = access_err(i_addr, i_memSize);
      size_p0  = i_memSize;
      off_p0   = i_addr[1:0];
      idx_p0   = word_index(i_addr);
    end
  end

  // ---- accept: capture request ----
  always_ff @(posedge clk) begin
    if (accept) begin
      write_p1 <= i_write;
      err_p1   <= access_err(i_addr, i_memSize);
      size_p1  <= i_memSize;
      off_p1   <= i_addr[1:0];
      idx_p1   <= word_index(i_addr);
      wdata_p1 <= i_wdata;
    end
  end

  // ---- control FSM and registered response ----
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      wait_cnt <= 4'd0;
      o_ready  <= 1'b0;
      o_err    <= 1'b0;
      o_rdata  <= 32'd0;
    end else begin
      o_ready <= go_resp;
      o_err   <= go_resp & err_p0;
      // Any earlier store committed at least one edge ago, so this read
      // always sees current array contents.
      if (go_resp)
        o_rdata <= (err_p0 || write_p0) ? 32'd0
                                        : load_lane(mem[idx_p0], off_p0, size_p0);
      unique case (state)
        S_IDLE: begin
          if (i_req) begin
            wait_cnt <= WAIT_INIT;
            state    <= NO_WAIT ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          if (!i_req)
            state <= S_IDLE;
          else if (wait_cnt == 4'd1)
            state <= S_RESP;
          else
            wait_cnt <= wait_cnt - 4'd1;
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // ---- response edge: store commit ----
  always_ff @(posedge clk) begin
    if (!reset && (state == S_RESP) && write_p1 && !err_p1)
      mem[idx_p1] <= store_merge(mem[idx_p1], wdata_p1, off_p1, size_p1);
  end

`ifdef DMEM_ACCESS_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      o_rdCount <= 32'd0;
      o_wrCount <= 32'd0;
    end else if ((state == S_RESP) && !err_p1) begin
      if (write_p1)
        o_wrCount <= o_wrCount + 32'd1;
      else
        o_rdCount <= o_rdCount + 32'd1;
    end
  end
`else
  assign o_rdCount = 32'd0;
  assign o_wrCount = 32'd0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (2 wait states / depth 4096, and
// 0 wait states / depth 16) driven one transaction at a time. A byte-level
// reference model of the memory window predicts every response; a single
// compare process checks the outputs each cycle, and literal expectations
// pin the model on the directed scenarios.

module tb_dmem_responder;

  localparam logic [31:0] BASE = 32'h0002_0000;
`ifdef DMEM_ACCESS_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  typedef struct {
    int        cyc;
    bit        w;
    bit [31:0] a;
    bit [31:0] wd;
    bit [1:0]  sz;
  } txn_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req, wr, ready, stall, err;
  logic [31:0] addr [2];
  logic [31:0] wdata [2];
  logic [1:0]  size [2];
  logic [31:0] rdata [2];
  logic [31:0] rdc [2];
  logic [31:0] wrc [2];

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  txn_t pend [2];
  bit   pend_v [2];
  int   rd_m [2];
  int   wr_m [2];
  bit [31:0] mm [int];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(4096), .WAIT_CYCLES(2)) u_dut0 (
    .clk(clk), .reset(reset), .i_req(req[0]), .i_write(wr[0]), .i_addr(addr[0]),
    .i_wdata(wdata[0]), .i_memSize(size[0]), .o_rdata(rdata[0]), .o_ready(ready[0]),
    .o_stall(stall[0]), .o_err(err[0]), .o_rdCount(rdc[0]), .o_wrCount(wrc[0]));

  dmem_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(16), .WAIT_CYCLES(0)) u_dut1 (
    .clk(clk), .reset(reset), .i_req(req[1]), .i_write(wr[1]), .i_addr(addr[1]),
    .i_wdata(wdata[1]), .i_memSize(size[1]), .o_rdata(rdata[1]), .o_ready(ready[1]),
    .o_stall(stall[1]), .o_err(err[1]), .o_rdCount(rdc[1]), .o_wrCount(wrc[1]));

  function automatic int depth_of(input int d);
    return (d == 0) ? 4096 : 16;
  endfunction

  function automatic int waits_of(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: treats the window as bytes. Returns error flag, load data and
  // whether the addressed word has known contents.
  function automatic void model_exec(input int d, input txn_t t, output bit e,
                                     output bit [31:0] rd, output bit known);
    longint    rel;
    int        nb, p, key;
    bit [31:0] word;
    rel = longint'(t.a) - longint'(BASE);
    nb  = (t.sz == 2'd0) ? 1 : (t.sz == 2'd1) ? 2 : 4;
    e   = (t.sz == 2'd3) || (rel < 0) || (rel >= 4 * longint'(depth_of(d)))
       || ((t.a % nb) != 0);
    rd    = 32'd0;
    known = 1'b1;
    if (!e) begin
      key   = d * 65536 + int'(rel / 4);
      p     = int'(rel % 4);
      known = mm.exists(key);
      word  = known ? mm[key] : 32'd0;
      for (int k = 0; k < nb; k++) begin
        if (t.w) word[8*(p+k) +: 8] = t.wd[8*k +: 8];
        else     rd[8*k +: 8]       = word[8*(p+k) +: 8];
      end
      if (t.w && (known || nb == 4)) mm[key] = word;
    end
  endfunction

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (!reset) begin
      for (int d = 0; d < 2; d++) begin
        bit        exp_rdy, e, known;
        bit [31:0] rd;
        chk("stall", stall[d], req[d] & ~ready[d]);
        chk("rd_count", rdc[d], CNT_EN ? 32'(rd_m[d]) : 32'd0);
        chk("wr_count", wrc[d], CNT_EN ? 32'(wr_m[d]) : 32'd0);
        exp_rdy = pend_v[d] && (pend[d].cyc == cyc);
        chk("ready", ready[d], exp_rdy);
        if (exp_rdy) begin
          model_exec(d, pend[d], e, rd, known);
          chk("err", err[d], e);
          if (e || (!pend[d].w && known)) chk("rdata", rdata[d], rd);
          if (!e) begin
            if (pend[d].w) wr_m[d]++;
            else           rd_m[d]++;
          end
          pend_v[d] = 1'b0;
        end else if (pend_v[d] && cyc > pend[d].cyc) begin
          pend_v[d] = 1'b0;
        end
      end
    end
  end

  task automatic issue(input int d, input bit w, input bit [31:0] a,
                       input bit [31:0] wd, input bit [1:0] sz);
    req[d]   = 1'b1;
    wr[d]    = w;
    addr[d]  = a;
    wdata[d] = wd;
    size[d]  = sz;
    pend[d].cyc = cyc + 1 + waits_of(d);
    pend[d].w   = w;
    pend[d].a   = a;
    pend[d].wd  = wd;
    pend[d].sz  = sz;
    pend_v[d]   = 1'b1;
  endtask

  task automatic access(input int d, input bit w, input bit [31:0] a,
                        input bit [31:0] wd, input bit [1:0] sz,
                        output logic [31:0] rd, output logic e, output int lat);
    int start, n;
    start = cyc;
    issue(d, w, a, wd, sz);
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      if (ready[d] === 1'b1) break;
      n++;
    end
    if (n >= 40) begin
      errors++;
      checks++;
      $display("FAIL timeout: dut%0d addr %h no completion in 40 cycles", d, a);
      pend_v[d] = 1'b0;
    end
    rd  = rdata[d];
    e   = err[d];
    lat = cyc - start;
    @(posedge clk);
    #1;
    req[d] = 1'b0;
  endtask

  task automatic pulse_reset();
    reset  = 1'b1;
    req    = 2'b00;
    pend_v[0] = 1'b0;
    pend_v[1] = 1'b0;
    rd_m[0] = 0; rd_m[1] = 0;
    wr_m[0] = 0; wr_m[1] = 0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] rd;
    logic        e;
    int          lat;
    reset = 1'b1;
    req   = 2'b00;
    wr    = 2'b00;
    for (int d = 0; d < 2; d++) begin
      addr[d] = 32'd0; wdata[d] = 32'd0; size[d] = 2'd0;
      pend_v[d] = 1'b0; rd_m[d] = 0; wr_m[d] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_ready", ready[d], 0);
      chk("rst_err", err[d], 0);
      chk("rst_rdata", rdata[d], 0);
      chk("rst_rdcount", rdc[d], 0);
      chk("rst_wrcount", wrc[d], 0);
    end
    @(posedge clk);
    #1;

    // Word store/load
    access(0, 1, 32'h0002_0010, 32'hDEAD_BEEF, 2'b10, rd, e, lat);
    chk("sw_latency", lat, 3);
    chk("sw_err", e, 0);
    access(0, 0, 32'h0002_0010, 32'd0, 2'b10, rd, e, lat);
    chk("lw_data", rd, 32'hDEAD_BEEF);

    // Byte/half lanes
    access(0, 1, 32'h0002_0012, 32'h0000_005A, 2'b00, rd, e, lat);
    access(0, 0, 32'h0002_0010, 32'd0, 2'b10, rd, e, lat);
    chk("sb_then_lw", rd, 32'hDE5A_BEEF);
    access(0, 0, 32'h0002_0012, 32'd0, 2'b01, rd, e, lat);
    chk("lh_data", rd, 32'h0000_DE5A);

    // Misaligned
    access(0, 0, 32'h0002_0011, 32'd0, 2'b10, rd, e, lat);
    chk("lw_mis_err", e, 1);
    chk("lw_mis_rdata", rd, 0);
    access(0, 1, 32'h0002_0013, 32'h0000_1234, 2'b01, rd, e, lat);
    chk("sh_mis_err", e, 1);
    access(0, 0, 32'h0002_0010, 32'd0, 2'b10, rd, e, lat);
    chk("sh_mis_nochange", rd, 32'hDE5A_BEEF);

    // Out of range (indices would alias to the last and first words)
    access(0, 1, 32'h0002_0000, 32'hA0A0_A0A0, 2'b10, rd, e, lat);
    access(0, 1, 32'h0002_3FFC, 32'hB0B0_B0B0, 2'b10, rd, e, lat);
    access(0, 1, 32'h0001_FFFC, 32'h1111_1111, 2'b10, rd, e, lat);
    chk("below_err", e, 1);
    access(0, 1, 32'h0002_4000, 32'h2222_2222, 2'b10, rd, e, lat);
    chk("above_err", e, 1);
    access(0, 0, 32'h0002_0000, 32'd0, 2'b10, rd, e, lat);
    chk("first_word_kept", rd, 32'hA0A0_A0A0);
    access(0, 0, 32'h0002_3FFC, 32'd0, 2'b10, rd, e, lat);
    chk("last_word_kept", rd, 32'hB0B0_B0B0);

    // Abort in WAIT
    issue(0, 1, 32'h0002_0010, 32'h1111_1111, 2'b10);
    @(posedge clk);
    #1;
    req[0]    = 1'b0;
    pend_v[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    access(0, 0, 32'h0002_0010, 32'd0, 2'b10, rd, e, lat);
    chk("abort_nochange", rd, 32'hDE5A_BEEF);

    // Reset in WAIT
    issue(0, 1, 32'h0002_0010, 32'h2222_2222, 2'b10);
    @(posedge clk);
    #1;
    pulse_reset();
    chk("rst_wait_ready", ready[0], 0);
    chk("rst_wait_rdata", rdata[0], 0);
    reset = 1'b0;
    access(0, 0, 32'h0002_0010, 32'd0, 2'b10, rd, e, lat);
    chk("rst_wait_nochange", rd, 32'hDE5A_BEEF);
    chk("rst_wait_idle_lat", lat, 3);

    // Zero wait states: prefill, then 3 LW + 2 SW back-to-back
    for (int i = 0; i < 16; i++)
      access(1, 1, BASE + 32'(4 * i), $urandom, 2'b10, rd, e, lat);
    pulse_reset();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      access(1, 0, BASE + 32'(4 * i), 32'd0, 2'b10, rd, e, lat);
      chk("w0_lw_latency", lat, 1);
    end
    for (int i = 0; i < 2; i++) begin
      access(1, 1, BASE + 32'(4 * i + 20), $urandom, 2'b10, rd, e, lat);
      chk("w0_sw_latency", lat, 1);
    end
    @(negedge clk);
    chk("end_rdcount", rdc[1], CNT_EN ? 32'd3 : 32'd0);
    chk("end_wrcount", wrc[1], CNT_EN ? 32'd2 : 32'd0);
    @(posedge clk);
    #1;

    // Random traffic around the small window
    for (int i = 0; i < 300; i++)
      access(1, 1'($urandom), BASE - 32'd8 + 32'($urandom_range(0, 79)), $urandom,
             2'($urandom_range(0, 3)), rd, e, lat);

    // Random traffic on the waited instance, with occasional aborts
    for (int i = 0; i < 8; i++)
      access(0, 1, BASE + 32'(4 * i), $urandom, 2'b10, rd, e, lat);
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        issue(0, 1'($urandom), BASE + 32'($urandom_range(0, 31)), $urandom,
              2'($urandom_range(0, 3)));
        @(posedge clk);
        #1;
        req[0]    = 1'b0;
        pend_v[0] = 1'b0;
        @(posedge clk);
        #1;
      end else begin
        access(0, 1'($urandom), BASE - 32'd8 + 32'($urandom_range(0, 39)), $urandom,
               2'($urandom_range(0, 3)), rd, e, lat);
      end
    end

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
